// File: rtl/vga_mon_pkg.sv
// Shared types, widths and the signature fold used by the VGA frame monitor.
package vga_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        CAPTURE,
        DONE
    } state_t;

    localparam int SIG_W = 32;
    localparam int CNT_W = 16;

    // Rotate-left by one, then fold in the zero-extended pixel.
    function automatic logic [SIG_W-1:0] sig_next(input logic [SIG_W-1:0] acc,
                                                  input logic [SIG_W-1:0] pix);
        return {acc[SIG_W-2:0], acc[SIG_W-1]} ^ pix;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers a sync pin and flags the cycle where the registered level turns active.
module sync_edge_det #(
    parameter bit POL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_i,
    output logic start_o
);

    logic lvl_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q  <= ~POL;
            prev_q <= ~POL;
        end else begin
            lvl_q  <= sync_i;
            prev_q <= lvl_q;
        end
    end

    assign start_o = (lvl_q == POL) && (prev_q != POL);

endmodule

// File: rtl/vga_frame_monitor.sv
// VGA frame monitor: measures line/frame periods and folds each frame into a signature.
// Define VGA_MON_STICKY_ERR_EN to make err_h/err_v sticky until reset or re-arm.
module vga_frame_monitor
    import vga_mon_pkg::*;
#(
    parameter int H_TOTAL = 1056,
    parameter int V_TOTAL = 628,
    parameter int COLOR_W = 4,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int FRAMES  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               hs,
    input  logic               vs,
    input  logic [COLOR_W-1:0] r,
    input  logic [COLOR_W-1:0] g,
    input  logic [COLOR_W-1:0] b,
    output logic               frame_done,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic [CNT_W-1:0]   h_meas,
    output logic [CNT_W-1:0]   v_meas,
    output logic [SIG_W-1:0]   signature,
    output logic               err_h,
    output logic               err_v,
    output logic               done
);

    if (3 * COLOR_W > SIG_W) begin : g_width_check
        $error("vga_frame_monitor: 3*COLOR_W must not exceed %0d", SIG_W);
    end

`ifdef VGA_MON_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    localparam logic [CNT_W-1:0] H_EXP    = CNT_W'(H_TOTAL);
    localparam logic [CNT_W-1:0] V_EXP    = CNT_W'(V_TOTAL);
    localparam logic [CNT_W-1:0] FRAMES_C = CNT_W'(FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [CNT_W-1:0] h_meas_q, h_meas_d;
    logic [CNT_W-1:0] v_meas_q, v_meas_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [SIG_W-1:0] acc_q, acc_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic             err_h_q, err_h_d;
    logic             err_v_q, err_v_d;
    logic             frame_done_q, frame_done_d;
    logic             done_q, done_d;

    logic             hs_start;
    logic             vs_start;
    logic [SIG_W-1:0] pix;
    logic [CNT_W-1:0] hcnt_inc;
    logic [CNT_W-1:0] vcnt_inc;
    logic [CNT_W-1:0] frame_cnt_inc;

    sync_edge_det #(.POL(HS_POL)) u_hs_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .sync_i (hs),
        .start_o(hs_start)
    );

    sync_edge_det #(.POL(VS_POL)) u_vs_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .sync_i (vs),
        .start_o(vs_start)
    );

    assign pix           = SIG_W'({r, g, b});
    assign hcnt_inc      = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + CNT_W'(1);
    assign frame_cnt_inc = (frame_cnt_q == CNT_MAX) ? CNT_MAX : frame_cnt_q + CNT_W'(1);
    // The line count includes the line closed by an hs start in this same cycle.
    assign vcnt_inc      = (!hs_start || vcnt_q == CNT_MAX) ? vcnt_q : vcnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        h_meas_d     = h_meas_q;
        v_meas_d     = v_meas_q;
        frame_cnt_d  = frame_cnt_q;
        acc_d        = acc_q;
        sig_d        = sig_q;
        err_h_d      = err_h_q;
        err_v_d      = err_v_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d     = SYNC;
                    frame_cnt_d = '0;
                    if (STICKY) begin
                        err_h_d = 1'b0;
                        err_v_d = 1'b0;
                    end
                end
            end
            SYNC: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (vs_start) begin
                    state_d = CAPTURE;
                    hcnt_d  = '0;
                    vcnt_d  = '0;
                    acc_d   = pix;
                end
            end
            CAPTURE: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    hcnt_d = hcnt_inc;
                    vcnt_d = vcnt_inc;
                    acc_d  = sig_next(acc_q, pix);
                    // A line running past its expected end flags err_h before hs arrives.
                    if (hs_start) begin
                        hcnt_d   = '0;
                        h_meas_d = hcnt_inc;
                        err_h_d  = (STICKY && err_h_q) || (hcnt_inc != H_EXP);
                    end else if (hcnt_q >= H_EXP) begin
                        err_h_d = 1'b1;
                    end
                    if (vs_start) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_inc;
                        v_meas_d     = vcnt_inc;
                        err_v_d      = (STICKY && err_v_q) || (vcnt_inc != V_EXP);
                        sig_d        = acc_q;
                        acc_d        = pix;
                        vcnt_d       = '0;
                        if (FRAMES != 0 && frame_cnt_inc == FRAMES_C) begin
                            state_d = DONE;
                        end
                    end else if (hs_start && vcnt_inc > V_EXP) begin
                        err_v_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!en) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            h_meas_q     <= '0;
            v_meas_q     <= '0;
            frame_cnt_q  <= '0;
            acc_q        <= '0;
            sig_q        <= '0;
            err_h_q      <= 1'b0;
            err_v_q      <= 1'b0;
            frame_done_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            h_meas_q     <= h_meas_d;
            v_meas_q     <= v_meas_d;
            frame_cnt_q  <= frame_cnt_d;
            acc_q        <= acc_d;
            sig_q        <= sig_d;
            err_h_q      <= err_h_d;
            err_v_q      <= err_v_d;
            frame_done_q <= frame_done_d;
            done_q       <= done_d;
        end
    end

    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign h_meas     = h_meas_q;
    assign v_meas     = v_meas_q;
    assign signature  = sig_q;
    assign err_h      = err_h_q;
    assign err_v      = err_v_q;
    assign done       = done_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Directed bench for vga_frame_monitor on a shrunken 8x4 raster; one FRAMES=2 and one FRAMES=0 instance.
module tb_vga_frame_monitor;

    localparam int H         = 8;
    localparam int V         = 4;
    localparam int FRAME_PIX = H * V;
    localparam int HS_W      = 2;

`ifdef VGA_MON_STICKY_ERR_EN
    localparam logic STICKY_EXP = 1'b1;
`else
    localparam logic STICKY_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        hs;
    logic        vs;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;

    logic        dutFrameDone, freeFrameDone;
    logic [15:0] dutFrameCnt, freeFrameCnt;
    logic [15:0] dutHMeas, freeHMeas;
    logic [15:0] dutVMeas, freeVMeas;
    logic [31:0] dutSig, freeSig;
    logic        dutErrH, freeErrH;
    logic        dutErrV, freeErrV;
    logic        dutDone, freeDone;

    int          vectors = 0;
    int          miscompares = 0;
    int          pos = 0;
    bit          rampMode = 1'b0;
    logic [31:0] sigRef;

    always #5 clk = ~clk;

    vga_frame_monitor #(
        .H_TOTAL(H), .V_TOTAL(V), .COLOR_W(4), .HS_POL(1'b0), .VS_POL(1'b0), .FRAMES(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
        .frame_done(dutFrameDone), .frame_cnt(dutFrameCnt), .h_meas(dutHMeas),
        .v_meas(dutVMeas), .signature(dutSig), .err_h(dutErrH), .err_v(dutErrV),
        .done(dutDone)
    );

    vga_frame_monitor #(
        .H_TOTAL(H), .V_TOTAL(V), .COLOR_W(4), .HS_POL(1'b0), .VS_POL(1'b0), .FRAMES(0)
    ) u_free (
        .clk(clk), .rst_n(rst_n), .en(en), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
        .frame_done(freeFrameDone), .frame_cnt(freeFrameCnt), .h_meas(freeHMeas),
        .v_meas(freeVMeas), .signature(freeSig), .err_h(freeErrH), .err_v(freeErrV),
        .done(freeDone)
    );

    function automatic logic [11:0] rampPix(input int p);
        return 12'(p * 37 + 5);
    endfunction

    // vs start is acted on one pixel after the pin goes active, so a captured
    // frame runs from pixel 1 of one frame to pixel 0 of the next.
    function automatic logic [31:0] refSignature();
        logic [31:0] acc;
        acc = '0;
        for (int i = 1; i <= FRAME_PIX; i++) begin
            acc = {acc[30:0], acc[31]} ^ {20'h0, rampPix(i % FRAME_PIX)};
        end
        return acc;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            hs = 1'b1;
            vs = 1'b1;
            {r, g, b} = 12'h000;
        end
    endtask

    task automatic applyStimulus(input int n);
        int p;
        int x;
        repeat (n) begin
            @(negedge clk);
            p = pos % FRAME_PIX;
            x = pos % H;
            hs = (x < HS_W) ? 1'b0 : 1'b1;
            vs = (p < H) ? 1'b0 : 1'b1;
            {r, g, b} = rampMode ? rampPix(p) : 12'h000;
            pos++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        hs    = 1'b1;
        vs    = 1'b1;
        {r, g, b} = 12'h000;
        sigRef = refSignature();

        idleCycles(2);
        checkOutput("reset_frame_cnt", 32'(dutFrameCnt), 32'd0);
        checkOutput("reset_signature", dutSig, 32'd0);
        checkOutput("reset_done", 32'(dutDone), 32'd0);
        checkOutput("reset_h_meas", 32'(dutHMeas), 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        idleCycles(2);

        $display("[TB] constant black frames");
        applyStimulus(35);
        checkOutput("f1_frame_done", 32'(dutFrameDone), 32'd1);
        checkOutput("f1_frame_cnt", 32'(dutFrameCnt), 32'd1);
        checkOutput("f1_h_meas", 32'(dutHMeas), 32'd8);
        checkOutput("f1_v_meas", 32'(dutVMeas), 32'd4);
        checkOutput("f1_done", 32'(dutDone), 32'd0);
        applyStimulus(32);
        checkOutput("f2_frame_done", 32'(dutFrameDone), 32'd1);
        checkOutput("f2_frame_cnt", 32'(dutFrameCnt), 32'd2);
        checkOutput("f2_done", 32'(dutDone), 32'd1);
        checkOutput("f2_err_h", 32'(dutErrH), 32'd0);
        checkOutput("f2_err_v", 32'(dutErrV), 32'd0);
        checkOutput("f2_signature", dutSig, 32'd0);
        checkOutput("free_f2_done", 32'(freeDone), 32'd0);

        $display("[TB] free-running to five frames");
        applyStimulus(96);
        checkOutput("free_f5_frame_cnt", 32'(freeFrameCnt), 32'd5);
        checkOutput("free_f5_done", 32'(freeDone), 32'd0);
        checkOutput("free_f5_v_meas", 32'(freeVMeas), 32'd4);
        checkOutput("free_f5_err_v", 32'(freeErrV), 32'd0);
        checkOutput("held_frame_cnt", 32'(dutFrameCnt), 32'd2);
        checkOutput("held_done", 32'(dutDone), 32'd1);

        $display("[TB] one short line");
        applyStimulus(12);
        pos++;
        applyStimulus(3);
        checkOutput("short_h_meas", 32'(freeHMeas), 32'd7);
        checkOutput("short_err_h", 32'(freeErrH), 32'd1);
        applyStimulus(8);
        checkOutput("good_h_meas", 32'(freeHMeas), 32'd8);
        checkOutput("good_err_h", 32'(freeErrH), 32'(STICKY_EXP));

        $display("[TB] disarm, partial frame, re-arm");
        en = 1'b0;
        applyStimulus(2);
        checkOutput("disarm_done", 32'(dutDone), 32'd0);
        checkOutput("disarm_free_cnt_held", 32'(freeFrameCnt), 32'd5);
        applyStimulus(3);
        rampMode = 1'b1;
        en = 1'b1;
        applyStimulus(16);
        en = 1'b0;
        applyStimulus(2);
        checkOutput("drop_frame_cnt", 32'(dutFrameCnt), 32'd0);
        checkOutput("drop_free_frame_cnt", 32'(freeFrameCnt), 32'd0);
        applyStimulus(17);
        checkOutput("idle_frame_cnt", 32'(dutFrameCnt), 32'd0);
        checkOutput("idle_frame_done", 32'(dutFrameDone), 32'd0);
        en = 1'b1;

        $display("[TB] ramp frames");
        applyStimulus(64);
        checkOutput("ramp1_frame_cnt", 32'(dutFrameCnt), 32'd1);
        checkOutput("ramp1_signature", dutSig, sigRef);
        checkOutput("ramp1_free_signature", freeSig, sigRef);
        checkOutput("ramp1_free_err_h", 32'(freeErrH), 32'd0);
        checkOutput("ramp1_v_meas", 32'(dutVMeas), 32'd4);
        applyStimulus(32);
        checkOutput("ramp2_frame_cnt", 32'(dutFrameCnt), 32'd2);
        checkOutput("ramp2_done", 32'(dutDone), 32'd1);
        checkOutput("ramp2_signature", dutSig, sigRef);
        checkOutput("ramp2_free_frame_cnt", 32'(freeFrameCnt), 32'd2);
        checkOutput("ramp2_h_meas", 32'(dutHMeas), 32'd8);

        $display("[TB] asynchronous reset mid-capture");
        applyStimulus(5);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("areset_free_frame_cnt", 32'(freeFrameCnt), 32'd0);
        checkOutput("areset_free_h_meas", 32'(freeHMeas), 32'd0);
        checkOutput("areset_free_v_meas", 32'(freeVMeas), 32'd0);
        checkOutput("areset_free_signature", freeSig, 32'd0);
        checkOutput("areset_done", 32'(dutDone), 32'd0);
        checkOutput("areset_signature", dutSig, 32'd0);
        idleCycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
